// File: rtl/move_scheduler.sv
// move_scheduler: turns gravity ticks and button activity into single
// commands for the game core. It keeps one pending bit per op, auto-repeats
// held buttons, and offers one command at a time over a valid/ready port.
//
// Handshake: cmd_valid/cmd_op are driven from registers. Once cmd_valid
// rises, both hold steady until the core samples cmd_valid && cmd_ready on a
// rising edge. A transfer happens on exactly that edge, and cmd_valid is
// never withdrawn before then (game_over does not withdraw it either).
module move_scheduler #(
  parameter int REPEAT_DELAY = 2
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        tick_gravity,
  input  logic        tick_repeat,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rot_l,
  input  logic        btn_rot_r,
  input  logic        btn_down,
  input  logic        game_over,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [15:0] gravity_count,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [2:0] OP_GRAVITY = 3'd1;
  localparam logic [2:0] OP_LEFT    = 3'd2;
  localparam logic [2:0] OP_RIGHT   = 3'd3;
  localparam logic [2:0] OP_ROT_L   = 3'd4;
  localparam logic [2:0] OP_ROT_R   = 3'd5;
  localparam logic [2:0] OP_DROP    = 3'd6;

  localparam logic [2:0] RPT_LIMIT = 3'(REPEAT_DELAY);

  // Pending bit i belongs to op i+1:
  // 0 gravity, 1 left, 2 right, 3 rot_l, 4 rot_r, 5 drop.
  logic [1:0]  state;
  logic [5:0]  pend;
  logic [4:0]  btn_prev;     // {down, rot_r, rot_l, right, left}
  logic [2:0]  hold_cnt [4]; // left, right, rot_l, rot_r

  logic [3:0]  btn_lvl;
  logic [3:0]  btn_rise;
  logic [3:0]  hold_hit;
  logic        drop_set;
  logic [5:0]  set_ev;
  logic [5:0]  cancel_mask;
  logic [5:0]  accept_mask;
  logic [5:0]  eff;
  logic [5:0]  pend_nxt;
  logic [2:0]  win_op;

  assign btn_lvl   = {btn_rot_r, btn_rot_l, btn_right, btn_left};
  assign dbg_state = state;

  // Event detection, opposing-pair cancellation, priority pick and the pending update.
  always_comb begin
    btn_rise = btn_lvl & ~btn_prev[3:0];
    hold_hit = '0;
    for (int i = 0; i < 4; i++) begin
      hold_hit[i] = tick_repeat && btn_lvl[i] && (hold_cnt[i] == RPT_LIMIT);
    end
    drop_set = (btn_down && !btn_prev[4]) || (tick_repeat && btn_down);
    set_ev   = {drop_set, btn_rise | hold_hit, tick_gravity};

    // When both ops of an opposing pair are pending, the player's intent is
    // unclear, so both are dropped and neither is issued.
    cancel_mask = '0;
    if (pend[1] && pend[2]) cancel_mask[2:1] = 2'b11;
    if (pend[3] && pend[4]) cancel_mask[4:3] = 2'b11;
    eff = pend & ~cancel_mask;

    accept_mask = '0;
    if (state == S_ISSUE && cmd_valid && cmd_ready) begin
      for (int i = 0; i < 6; i++) begin
        if (cmd_op == 3'(i + 1)) accept_mask[i] = 1'b1;
      end
    end

    // A new event always survives a clear on the same edge.
    pend_nxt = (pend & ~(cancel_mask | accept_mask)) | set_ev;

    win_op = 3'd0;
    if      (eff[0]) win_op = OP_GRAVITY;
    else if (eff[3]) win_op = OP_ROT_L;
    else if (eff[4]) win_op = OP_ROT_R;
    else if (eff[1]) win_op = OP_LEFT;
    else if (eff[2]) win_op = OP_RIGHT;
    else if (eff[5]) win_op = OP_DROP;
  end

  // Pending bits, hold counters, button history, FSM, command outputs and gravity counter.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      pend          <= '0;
      btn_prev      <= '0;
      for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
      cmd_valid     <= 1'b0;
      cmd_op        <= 3'd0;
      gravity_count <= 16'd0;
    end else begin
      btn_prev <= {btn_down, btn_lvl};

      if (state == S_HALT) begin
        pend <= '0;
        for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
      end else begin
        pend <= pend_nxt;
        for (int i = 0; i < 4; i++) begin
          if (!btn_lvl[i])
            hold_cnt[i] <= '0;
          else if (tick_repeat && hold_cnt[i] != RPT_LIMIT)
            hold_cnt[i] <= hold_cnt[i] + 3'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (game_over) begin
            state <= S_HALT;
          end else if (|eff) begin
            cmd_op    <= win_op;
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_valid && cmd_ready) begin
            if ((cmd_op == OP_GRAVITY || cmd_op == OP_DROP) && gravity_count != 16'hFFFF)
              gravity_count <= gravity_count + 16'd1;
            cmd_valid <= 1'b0;
            cmd_op    <= 3'd0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          state <= game_over ? S_HALT : S_IDLE;
        end
        default: begin
          if (!game_over) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: a per-cycle vector table followed by
// hand-written sequences for auto-repeat, stalled handshakes with game_over,
// asynchronous reset, power-up button edges and counter saturation.
module tb_move_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_gravity, tick_repeat;
  logic        btn_left, btn_right, btn_rot_l, btn_rot_r, btn_down;
  logic        game_over, cmd_ready;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [15:0] gravity_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];

  typedef struct {
    logic       tg, tr, l, r, rl, rr, dn, go;
    logic       ev;
    logic [2:0] eop;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  move_scheduler #(.REPEAT_DELAY(2)) dut (
    .clk_100MHz    (clk),
    .reset         (reset),
    .tick_gravity  (tick_gravity),
    .tick_repeat   (tick_repeat),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_rot_l     (btn_rot_l),
    .btn_rot_r     (btn_rot_r),
    .btn_down      (btn_down),
    .game_over     (game_over),
    .cmd_ready     (cmd_ready),
    .cmd_valid     (cmd_valid),
    .cmd_op        (cmd_op),
    .gravity_count (gravity_count),
    .dbg_state     (dbg_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic tg, tr, l, r, rl, rr, dn, go,
                     input logic ev, input logic [2:0] eop, input logic [15:0] ecnt);
    vec_t v;
    v.tg = tg; v.tr = tr; v.l = l; v.r = r; v.rl = rl; v.rr = rr; v.dn = dn; v.go = go;
    v.ev = ev; v.eop = eop; v.ecnt = ecnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    tick_gravity = v.tg; tick_repeat = v.tr;
    btn_left = v.l; btn_right = v.r; btn_rot_l = v.rl; btn_rot_r = v.rr;
    btn_down = v.dn; game_over = v.go;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for cmd_valid with a bounded cycle budget; reports timeout as a failed check.
  task automatic wait_valid(input string nm, input int budget);
    int n;
    n = 0;
    while (!cmd_valid && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_offer"}, 32'(cmd_valid), 32'd1);
  endtask

  initial begin
    int seen;
    int stable_bad;
    logic [2:0] got;

    reset = 1'b0; cmd_ready = 1'b1;
    tick_gravity = 0; tick_repeat = 0; btn_left = 0; btn_right = 0;
    btn_rot_l = 0; btn_rot_r = 0; btn_down = 0; game_over = 0;
    repeat (3) step();
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_op",    32'(cmd_op), 32'd0);
    chk("rst_cnt",   32'(gravity_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk) reset = 1'b1;

    //   tg tr l  r  rl rr dn go   ev eop cnt
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);   // 0 idle
    add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0);   // 1 gravity tick -> pending
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0);   // 2 offered
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1);   // 3 accepted
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1);   // 4 gap -> idle
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1);   // 5
    add(1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1);   // 6 gravity + left rise
    add(0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 1);   // 7 gravity first
    add(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2);   // 8 accepted
    add(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2);   // 9 gap -> idle
    add(0, 0, 1, 0, 0, 0, 0, 0,  1, 2, 2);   // 10 left offered
    add(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 2);   // 11 left accepted, not counted
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2);   // 12
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2);   // 13
    add(0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 2);   // 14 left+right rise
    add(0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 2);   // 15 cancelled
    add(0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 2);   // 16
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2);   // 17
    add(0, 0, 0, 0, 1, 0, 1, 0,  0, 0, 2);   // 18 rot_l + down rise
    add(0, 0, 0, 0, 1, 0, 0, 0,  1, 4, 2);   // 19 rot_l beats drop
    add(0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 2);   // 20
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2);   // 21
    add(0, 0, 0, 0, 0, 0, 0, 0,  1, 6, 2);   // 22 drop offered
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3);   // 23 drop counted
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3);   // 24
    add(1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 3);   // 25 game_over in idle -> halt
    add(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 3);   // 26 halt clears pending
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3);   // 27 -> idle
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3);   // 28 nothing left to issue
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3);   // 29
    add(0, 0, 1, 0, 0, 1, 0, 0,  0, 0, 3);   // 30 rot_r + left rise
    add(0, 0, 1, 0, 0, 1, 0, 0,  1, 5, 3);   // 31 rot_r first
    add(0, 0, 1, 0, 0, 1, 0, 0,  0, 0, 3);   // 32
    add(0, 0, 1, 0, 0, 1, 0, 0,  0, 0, 3);   // 33
    add(0, 0, 1, 0, 0, 1, 0, 0,  1, 2, 3);   // 34 then left
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3);   // 35
    add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3);   // 36

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk) drive(tbl[i]);
      step();
      chk($sformatf("vec%0d_valid", i), 32'(cmd_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_op", i),    32'(cmd_op), 32'(tbl[i].eop));
      chk($sformatf("vec%0d_cnt", i),   32'(gravity_count), 32'(tbl[i].ecnt));
    end

    // Auto-repeat: right held, five repeat ticks -> edge command + three repeats.
    repeat (4) exp_q.push_back(3'd3);
    seen = 0;
    @(negedge clk) btn_right = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (cmd_valid) begin
        seen++;
        if (exp_q.size() == 0) begin
          chk("rpt_extra_cmd", 32'(cmd_op), 32'd0);
        end else begin
          got = exp_q.pop_front();
          chk($sformatf("rpt_op%0d", seen), 32'(cmd_op), 32'(got));
        end
      end
      @(negedge clk) tick_repeat = (c % 6 == 2) && (c < 30);
    end
    @(negedge clk) begin btn_right = 1'b0; tick_repeat = 1'b0; end
    repeat (4) step();
    chk("rpt_count", 32'(seen), 32'd4);
    chk("rpt_queue_empty", 32'(exp_q.size()), 32'd0);

    // Stalled ROT_L with game_over rising mid-stall.
    @(negedge clk) begin cmd_ready = 1'b0; btn_rot_l = 1'b1; end
    step();
    wait_valid("stall", 10);
    chk("stall_op", 32'(cmd_op), 32'd4);
    stable_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk) game_over = (i >= 50);
      step();
      if (!(cmd_valid === 1'b1 && cmd_op === 3'd4)) stable_bad++;
    end
    chk("stall_stable", 32'(stable_bad), 32'd0);
    @(negedge clk) cmd_ready = 1'b1;
    step();
    chk("stall_acc_valid", 32'(cmd_valid), 32'd0);
    chk("stall_acc_op",    32'(cmd_op), 32'd0);
    chk("stall_gap_state", 32'(dbg_state), 32'd2);
    @(negedge clk) btn_rot_l = 1'b0;
    step();
    chk("stall_halt_state", 32'(dbg_state), 32'd3);
    chk("stall_halt_valid", 32'(cmd_valid), 32'd0);
    @(negedge clk) tick_gravity = 1'b1;
    step();
    chk("halt_ignores", 32'(dbg_state), 32'd3);
    @(negedge clk) begin tick_gravity = 1'b0; game_over = 1'b0; end
    step();
    chk("halt_exit_state", 32'(dbg_state), 32'd0);
    step();
    chk("halt_no_leftover", 32'(cmd_valid), 32'd0);

    // Asynchronous reset while a gravity command is offered.
    @(negedge clk) begin cmd_ready = 1'b0; tick_gravity = 1'b1; end
    @(negedge clk) tick_gravity = 1'b0;
    step();
    chk("mid_offer_valid", 32'(cmd_valid), 32'd1);
    chk("mid_offer_op",    32'(cmd_op), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(cmd_valid), 32'd0);
    chk("async_rst_op",    32'(cmd_op), 32'd0);
    chk("async_rst_cnt",   32'(gravity_count), 32'd0);

    // Button already high at reset release registers as a rising edge.
    btn_left = 1'b1;
    @(negedge clk) reset = 1'b1;
    step();
    chk("pwrup_edge1", 32'(cmd_valid), 32'd0);
    step();
    chk("pwrup_valid", 32'(cmd_valid), 32'd1);
    chk("pwrup_op",    32'(cmd_op), 32'd2);
    @(negedge clk) begin cmd_ready = 1'b1; btn_left = 1'b0; end
    repeat (4) step();
    chk("pwrup_cnt", 32'(gravity_count), 32'd0);

    // Counter saturation, starting just below the top.
    force dut.gravity_count = 16'hFFFC;
    #1 release dut.gravity_count;
    @(negedge clk) btn_down = 1'b1;
    step();
    wait_valid("sat_first", 10);
    step();
    chk("sat_first_cnt", 32'(gravity_count), 32'hFFFD);
    @(negedge clk) tick_repeat = 1'b1;
    repeat (30) step();
    @(negedge clk) begin tick_repeat = 1'b0; btn_down = 1'b0; end
    repeat (5) step();
    chk("sat_hold", 32'(gravity_count), 32'hFFFF);
    #2 reset = 1'b0;
    #1;
    chk("sat_rst_cnt", 32'(gravity_count), 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
